// File: rtl/up_down_cmd_gen.sv
// Turns two raw pushbuttons into clean single-cycle Up/Down step pulses for
// up_down_counter: synchronize, debounce, then a press/hold/auto-repeat FSM.
module up_down_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int REPEAT_CYCLES   = 4,
    parameter int TW              = 8
) (
    input  logic Clk,
    input  logic South,
    input  logic BtnUp,
    input  logic BtnDown,
    output logic Up,
    output logic Down,
    output logic Lock
);

    localparam logic [TW-1:0] DB_LAST     = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0] btn_raw;
    logic [1:0] deb_level;

    assign btn_raw = {BtnDown, BtnUp};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          deb_reg;
            logic [TW-1:0] db_cnt_reg;

            // A new level is accepted only after DEBOUNCE_CYCLES consecutive
            // disagreeing samples; any agreeing sample restarts the count.
            always_ff @(posedge Clk) begin
                if (South) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    deb_reg    <= 1'b0;
                    db_cnt_reg <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != deb_reg) begin
                        if (db_cnt_reg == DB_LAST) begin
                            deb_reg    <= ~deb_reg;
                            db_cnt_reg <= '0;
                        end else begin
                            db_cnt_reg <= db_cnt_reg + TIMER_ONE;
                        end
                    end else begin
                        db_cnt_reg <= '0;
                    end
                end
            end

            assign deb_level[gi] = deb_reg;
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        HOLD_UP,
        RPT_UP,
        HOLD_DN,
        RPT_DN,
        LOCK
    } state_t;

    state_t        state_reg;
    logic [TW-1:0] timer_reg;
    logic          du;
    logic          dd;

    assign du = deb_level[0];
    assign dd = deb_level[1];

    // Timer holds the cycles left until the next pulse; a pulse fires on the
    // cycle it reads 1, so a load of N places the next pulse N cycles later.
    always_ff @(posedge Clk) begin
        if (South) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            Up        <= 1'b0;
            Down      <= 1'b0;
            Lock      <= 1'b0;
        end else begin
            Up   <= 1'b0;
            Down <= 1'b0;
            Lock <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (du && dd) begin
                        state_reg <= LOCK;
                        Lock      <= 1'b1;
                    end else if (du) begin
                        Up        <= 1'b1;
                        timer_reg <= HOLD_LOAD;
                        state_reg <= HOLD_UP;
                    end else if (dd) begin
                        Down      <= 1'b1;
                        timer_reg <= HOLD_LOAD;
                        state_reg <= HOLD_DN;
                    end
                end
                HOLD_UP, RPT_UP: begin
                    if (!du) begin
                        state_reg <= IDLE;
                    end else if (dd) begin
                        state_reg <= LOCK;
                        Lock      <= 1'b1;
                    end else if (timer_reg == TIMER_ONE) begin
                        Up        <= 1'b1;
                        timer_reg <= REPEAT_LOAD;
                        state_reg <= RPT_UP;
                    end else begin
                        timer_reg <= timer_reg - TIMER_ONE;
                    end
                end
                HOLD_DN, RPT_DN: begin
                    if (!dd) begin
                        state_reg <= IDLE;
                    end else if (du) begin
                        state_reg <= LOCK;
                        Lock      <= 1'b1;
                    end else if (timer_reg == TIMER_ONE) begin
                        Down      <= 1'b1;
                        timer_reg <= REPEAT_LOAD;
                        state_reg <= RPT_DN;
                    end else begin
                        timer_reg <= timer_reg - TIMER_ONE;
                    end
                end
                LOCK: begin
                    // Stay locked until both buttons are released; leaving emits nothing.
                    if (!du && !dd) begin
                        state_reg <= IDLE;
                    end else begin
                        Lock <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
